keypad_scan_ctrl: RTL and testbench
===================================

# keypad_scan_ctrl

Parametrised matrix-keypad scanner for the CPLD front panel. It drives active-low column strobes and samples active-low row returns. Each key is debounced over whole scan frames and the encoded key is delivered through a valid/ack handshake. It also reports held-key status, a long-press pulse and, optionally, auto-repeat. It generalises the fixed 4×3 scan-and-encode logic in width, keypad size and behaviour.

## Interface
- COLS, 4: number of keypad columns (2..8)
- ROWS, 3: number of keypad rows (1..8)
- SCAN_W, 15: column dwell is 2^SCAN_W clocks
- DEB_N, 3: consecutive identical frames required to accept a press or a release (1..15)
- HOLD_W, 18: hold counter width; long press fires at 2^HOLD_W−1 clocks held
- CODE_W, $clog2(ROWS*COLS): key code width

Ports:
- f4m  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- row_n  in  ROWS  row returns, low = contact
- key_ack  in  1  consumer acknowledge
- col_n  out  COLS  column strobes, one-hot low
- key_code  out  CODE_W  row*COLS + col of the accepted key
- key_valid  out  1  new key available, held until acked
- key_held  out  1  debounced key currently down
- long_press  out  1  one-cycle pulse
- overrun  out  1  one-cycle pulse, press lost while key_valid was set

## Operation
- Scan counter sc = {col_idx, dwell[SCAN_W-1:0]} runs freely.
  - col_idx wraps at COLS−1.
  - col_n = ~(1<<col_idx).
- Rows are sampled on the last dwell clock (dwell all-ones) into a frame image of ROWS*COLS bits.
- Frame end is the sample clock of col_idx = COLS−1. At frame end: candidate = the single pressed key, or NONE if zero or ≥2 keys are pressed (multi-key rejection).
- The FSM advances only at frame end; cnt is 4 bits.
  - IDLE: candidate≠NONE → latch cand, cnt=1, go to DEB. If DEB_N=1, go directly to PRESSED.
  - DEB: candidate==cand → cnt++; cnt reaching DEB_N → PRESSED. Otherwise → IDLE.
  - PRESSED: candidate≠cand → REL, cnt=1.
  - REL: candidate==cand → PRESSED. Otherwise cnt++; cnt reaching DEB_N → IDLE.
- On entry to PRESSED from DEB:
  - if key_valid=0: key_code←cand, key_valid←1.
  - else: key_code unchanged, overrun pulses.
- key_valid is cleared on the clock after it samples key_ack=1. If a set and an ack occur in the same clock, the set wins.
- key_held = state∈{PRESSED, REL}. A REL→PRESSED bounce re-emits nothing.
- Hold counter hc (HOLD_W bits):
  - zero while key_held=0;
  - increments each clock while key_held=1, saturating at all-ones;
  - long_press=1 for exactly the clock in which hc becomes all-ones.

## Timing
- Reset values:
  - col_n = ~1 (column 0 active)
  - key_code = 0
  - key_valid, key_held, long_press, overrun = 0
  - sc, hc, cnt = 0; state IDLE
- Frame length F = COLS·2^SCAN_W clocks.
- Press latency: key_valid rises 1 clock after the DEB_N-th consecutive frame end showing the key.
- Release latency: key_held falls 1 clock after the DEB_N-th consecutive non-matching frame end.
- Asserting rst mid-debounce or mid-handshake drops any pending key. A held key after reset is re-detected as a new press.
- key_code is stable whenever key_valid=1.

## Configuration
- KEYPAD_REPEAT_EN defined:
  - after long_press, while key_held=1, a repeat tick fires every 2^(HOLD_W−2) clocks;
  - each tick sets key_valid with the same key_code, or pulses overrun if key_valid is already set;
  - the repeat timer clears on release.
- KEYPAD_REPEAT_EN undefined: a key produces exactly one key_valid per press and no repeat logic is instantiated.

## Test plan
Bench parameters: COLS=4, ROWS=3, SCAN_W=2, DEB_N=3, HOLD_W=6, so F=16.
- Reset: hold rst 3 clocks → col_n=4'b1110 and all outputs 0. Release rst → col_n steps 1110→1101→1011→0111, 4 clocks each, then wraps.
- Single press: hold row 1 low on column 2 (code 6) for 5 frames → key_valid=1 and key_code=6 after the 3rd frame end. Ack one clock → key_valid=0 the next clock.
- Bounce: toggle the key every frame for 6 frames → key_valid never rises. Steady release after an accepted press → key_held falls after 3 frames; a 1-frame dropout while held → no new key_valid.
- Multi-key: codes 0 and 5 pressed together → no key_valid. Release 5 while 0 stays down → key_code=0 after 3 frames.
- Overrun/long press: accept key 4 without ack, release, then accept key 9 → overrun pulse and key_code stays 4. Hold key 9 → long_press pulses once, 63 clocks after key_held rises.
- With KEYPAD_REPEAT_EN: after long_press, acking each key_valid → a new key_valid with code 9 every 16 clocks until release. Without the macro → none.

Source files
------------

// File: rtl/keypad_scan_ctrl_if.sv
// keypad_scan_ctrl_if: keypad matrix lines plus the key valid/ack handshake
// and status pulses of the keypad scanner.
// master = scanner side (drives column strobes and key outputs),
// slave  = keypad/consumer side (drives row returns and acknowledge).
interface keypad_scan_ctrl_if #(
    parameter int COLS   = 4,
    parameter int ROWS   = 3,
    parameter int CODE_W = $clog2(ROWS*COLS)
);
    logic [ROWS-1:0]   row_n;
    logic              key_ack;
    logic [COLS-1:0]   col_n;
    logic [CODE_W-1:0] key_code;
    logic              key_valid;
    logic              key_held;
    logic              long_press;
    logic              overrun;

    modport master (
        input  row_n, key_ack,
        output col_n, key_code, key_valid, key_held, long_press, overrun
    );

    modport slave (
        output row_n, key_ack,
        input  col_n, key_code, key_valid, key_held, long_press, overrun
    );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: matrix keypad scanner with frame-based debounce,
// multi-key rejection, valid/ack key delivery, held status and long press.
// Optional feature macro: KEYPAD_REPEAT_EN -- auto-repeat after long press.
// HOLD_W must be at least 3.
module keypad_scan_ctrl #(
    parameter int COLS   = 4,
    parameter int ROWS   = 3,
    parameter int SCAN_W = 15,
    parameter int DEB_N  = 3,
    parameter int HOLD_W = 18,
    parameter int CODE_W = $clog2(ROWS*COLS)
) (
    input  logic               f4m,
    input  logic               rst,
    keypad_scan_ctrl_if.master kp
);
    localparam int              NKEY     = ROWS * COLS;
    localparam int              CIW      = $clog2(COLS);
    localparam logic [CIW-1:0]  LAST_COL = CIW'(COLS - 1);
    localparam logic [3:0]      DEB_LIM  = 4'(DEB_N);
    localparam logic [HOLD_W-1:0] HC_PRE = {{(HOLD_W-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {S_IDLE, S_DEB, S_PRESSED, S_REL} state_t;

    logic [SCAN_W-1:0] dwell;
    logic [CIW-1:0]    col_idx;
    logic              sample, frame_end;
    logic [NKEY-1:0]   img, img_now;
    logic [1:0]        hits;
    logic [CODE_W-1:0] cand_code, cand_q, cand_d;
    logic              cand_one, match;
    state_t            state, state_d;
    logic [3:0]        cnt, cnt_d;
    logic              press, tick, emit, held;
    logic [HOLD_W-1:0] hc;
    logic [CODE_W-1:0] key_code_q;
    logic              key_valid_q, long_press_q, overrun_q;

    assign sample    = &dwell;
    assign frame_end = sample && (col_idx == LAST_COL);
    assign kp.col_n  = ~(COLS'(1) << col_idx);

    // Free-running scan counter: dwell per column, column wraps at COLS-1.
    always_ff @(posedge f4m or posedge rst) begin
        if (rst) begin
            dwell   <= '0;
            col_idx <= '0;
        end else begin
            dwell <= dwell + 1'b1;
            if (sample)
                col_idx <= (col_idx == LAST_COL) ? '0 : col_idx + 1'b1;
        end
    end

    // Capture the active column's rows on the last dwell clock.
    always_ff @(posedge f4m or posedge rst) begin
        if (rst) begin
            img <= '0;
        end else if (sample) begin
            for (int r = 0; r < ROWS; r++)
                img[r*COLS + int'(col_idx)] <= ~kp.row_n[r];
        end
    end

    // Full frame as seen at frame end (last column taken live) and its
    // single-key candidate; zero or several pressed keys give no candidate.
    always_comb begin
        img_now = img;
        for (int r = 0; r < ROWS; r++)
            img_now[r*COLS + COLS - 1] = ~kp.row_n[r];
        hits      = 2'd0;
        cand_code = '0;
        for (int i = 0; i < NKEY; i++) begin
            if (img_now[i]) begin
                cand_code = CODE_W'(i);
                if (hits != 2'd2) hits = hits + 2'd1;
            end
        end
    end

    assign cand_one = (hits == 2'd1);
    assign match    = cand_one && (cand_code == cand_q);

    // Debounce state, counter and latched candidate.
    always_ff @(posedge f4m or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            cand_q <= '0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            cand_q <= cand_d;
        end
    end

    // Debounce transitions, evaluated only at frame end.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        cand_d  = cand_q;
        press   = 1'b0;
        if (frame_end) begin
            case (state)
                S_IDLE: if (cand_one) begin
                    cand_d = cand_code;
                    cnt_d  = 4'd1;
                    if (DEB_N == 1) begin
                        state_d = S_PRESSED;
                        press   = 1'b1;
                    end else begin
                        state_d = S_DEB;
                    end
                end
                S_DEB: if (match) begin
                    cnt_d = cnt + 4'd1;
                    if (cnt + 4'd1 == DEB_LIM) begin
                        state_d = S_PRESSED;
                        press   = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
                S_PRESSED: if (!match) begin
                    cnt_d   = 4'd1;
                    state_d = (DEB_N == 1) ? S_IDLE : S_REL;
                end
                S_REL: if (match) begin
                    state_d = S_PRESSED;
                end else begin
                    cnt_d = cnt + 4'd1;
                    if (cnt + 4'd1 == DEB_LIM) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign held = (state == S_PRESSED) || (state == S_REL);

    // Hold counter saturates; long press marks the clock it reaches all-ones.
    always_ff @(posedge f4m or posedge rst) begin
        if (rst) begin
            hc           <= '0;
            long_press_q <= 1'b0;
        end else begin
            long_press_q <= held && (hc == HC_PRE);
            if (!held)     hc <= '0;
            else if (!(&hc)) hc <= hc + 1'b1;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    logic [HOLD_W-3:0] rt;

    // Repeat timer runs only after long press while the key stays down.
    always_ff @(posedge f4m or posedge rst) begin
        if (rst)                rt <= '0;
        else if (held && (&hc)) rt <= rt + 1'b1;
        else                    rt <= '0;
    end

    assign tick = held && (&hc) && (&rt);
`else
    assign tick = 1'b0;
`endif

    assign emit = press || tick;

    // Key handshake: a new key loads only into an empty slot, otherwise it
    // is reported as overrun; a new key outranks an ack in the same clock.
    always_ff @(posedge f4m or posedge rst) begin
        if (rst) begin
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (emit) begin
                if (!key_valid_q) begin
                    key_valid_q <= 1'b1;
                    key_code_q  <= cand_d;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (kp.key_ack) begin
                key_valid_q <= 1'b0;
            end
        end
    end

    assign kp.key_code   = key_code_q;
    assign kp.key_valid  = key_valid_q;
    assign kp.key_held   = held;
    assign kp.long_press = long_press_q;
    assign kp.overrun    = overrun_q;
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: physical keypad model driving row returns, a
// frame-level reference model that predicts key deliveries, overruns and
// long presses by edge number, and a monitor that consumes the predictions.
module tb_keypad_scan_ctrl;
    localparam int COLS = 4, ROWS = 3, SCAN_W = 2, DEB_N = 3, HOLD_W = 6;
    localparam int CODE_W = 4;
    localparam int F      = COLS * (1 << SCAN_W);
    localparam int LP_OFF = (1 << HOLD_W) - 1;
    localparam int REP    = 1 << (HOLD_W - 2);

    typedef struct { int at; int code; } exp_t;

    logic f4m = 1'b0;
    logic rst = 1'b1;
    logic [ROWS*COLS-1:0] keys;

    keypad_scan_ctrl_if #(.COLS(COLS), .ROWS(ROWS), .CODE_W(CODE_W)) kif ();

    keypad_scan_ctrl #(
        .COLS(COLS), .ROWS(ROWS), .SCAN_W(SCAN_W), .DEB_N(DEB_N),
        .HOLD_W(HOLD_W), .CODE_W(CODE_W)
    ) dut (
        .f4m (f4m),
        .rst (rst),
        .kp  (kif)
    );

    always #5 f4m = ~f4m;

    // Keypad contacts: a pressed key pulls its row low when its column is strobed.
    always_comb begin
        kif.row_n = '1;
        for (int c = 0; c < COLS; c++)
            if (!kif.col_n[c])
                for (int r = 0; r < ROWS; r++)
                    if (keys[r*COLS + c]) kif.row_n[r] = 1'b0;
    end

    int ecnt;
    always @(posedge f4m) begin
        if (rst) ecnt <= 0;
        else     ecnt <= ecnt + 1;
    end

    exp_t q_key[$];
    int   q_ovr[$];
    int   q_lp[$];
    int   nvec = 0, nerr = 0;
    int   held = -1, tent = -1, run = 0, miss = 0, hstart = 0;
    bit   pending = 1'b0, auto_ack = 1'b1;
    int   ack_req = 0;

    function automatic logic [ROWS*COLS-1:0] kb(input int idx);
        logic [ROWS*COLS-1:0] one;
        one = 1;
        return one << idx;
    endfunction

    function automatic int cand_of(input logic [ROWS*COLS-1:0] k);
        if ($countones(k) != 1) return -1;
        for (int i = 0; i < ROWS*COLS; i++) if (k[i]) return i;
        return -1;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        nvec++;
        if (act != req) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, ecnt);
        end
    endtask

    task automatic emit(input int x, input int code);
        exp_t e;
        if (!auto_ack && pending) begin
            q_ovr.push_back(x);
        end else begin
            e.at = x; e.code = code;
            q_key.push_back(e);
            if (!auto_ack) pending = 1'b1;
        end
    endtask

    // Reference: one call per frame, k = keys seen for the whole frame,
    // e = edge number of that frame's end.
    task automatic model_frame(input logic [ROWS*COLS-1:0] k, input int e);
        int c;
        c = cand_of(k);
        if (held < 0) begin
            if (tent < 0) begin
                if (c >= 0) begin tent = c; run = 1; end
            end else if (c == tent) begin
                run++;
            end else begin
                tent = -1; run = 0;
            end
            if (tent >= 0 && run == DEB_N) begin
                held = tent; hstart = e; tent = -1; run = 0; miss = 0;
                emit(e, held);
            end
        end else begin
            if (c == held) miss = 0;
            else begin
                miss++;
                if (miss == DEB_N) begin held = -1; miss = 0; end
            end
        end
        // Key still down through the next frame: schedule timed events in it.
        if (held >= 0) begin
            for (int x = e + 1; x <= e + F; x++) begin
                if (x == hstart + LP_OFF) q_lp.push_back(x);
`ifdef KEYPAD_REPEAT_EN
                if (x > hstart + LP_OFF && (x - hstart - LP_OFF) % REP == 0) emit(x, held);
`endif
            end
        end
    endtask

    task automatic run_frame(input logic [ROWS*COLS-1:0] k);
        keys = k;
        repeat (F) @(posedge f4m);
        #1;
        model_frame(k, ecnt);
    endtask

    task automatic frames(input logic [ROWS*COLS-1:0] k, input int n);
        repeat (n) run_frame(k);
    endtask

    task automatic do_reset();
        @(posedge f4m);
        #1 rst = 1'b1;
        held = -1; tent = -1; run = 0; miss = 0; pending = 1'b0;
        q_key.delete(); q_ovr.delete(); q_lp.delete();
        repeat (3) @(posedge f4m);
        @(negedge f4m);
        #1 rst = 1'b0;
    endtask

    // Monitor: compares every DUT event against the predicted queues.
    initial begin : monitor
        logic [COLS-1:0] exp_col, onec;
        logic kv_prev;
        int   cur_code, ack_done;
        exp_t e;
        kif.key_ack = 1'b0;
        kv_prev = 1'b0; cur_code = 0; ack_done = 0;
        onec = 1;
        forever begin
            @(negedge f4m);
            if (rst) begin
                nvec++;
                if (kif.col_n !== 4'b1110 || kif.key_valid !== 1'b0 || kif.key_held !== 1'b0 ||
                    kif.long_press !== 1'b0 || kif.overrun !== 1'b0 || kif.key_code !== '0) begin
                    nerr++;
                    $display("FAIL reset_state: col_n=%b valid=%b held=%b lp=%b ovr=%b code=%0d, expected 1110 0 0 0 0 0",
                             kif.col_n, kif.key_valid, kif.key_held, kif.long_press, kif.overrun, kif.key_code);
                end
                kv_prev = 1'b0;
                kif.key_ack = 1'b0;
            end else begin
                exp_col = ~(onec << ((ecnt % F) / (F / COLS)));
                chk("col_n", int'(kif.col_n), int'(exp_col));
                chk("key_held", int'(kif.key_held), (held >= 0) ? 1 : 0);
                if (kif.key_ack) begin
                    if (!(q_key.size() > 0 && q_key[0].at == ecnt) && !(q_ovr.size() > 0 && q_ovr[0] == ecnt))
                        chk("ack_clears_valid", int'(kif.key_valid), 0);
                    kif.key_ack = 1'b0;
                    kv_prev = kif.key_valid;
                end
                if (kif.key_valid && !kv_prev) begin
                    if (q_key.size() == 0) begin
                        nvec++; nerr++;
                        $display("FAIL unexpected_key_valid: code %0d at edge %0d, none expected", kif.key_code, ecnt);
                    end else begin
                        e = q_key.pop_front();
                        chk("key_valid_edge", ecnt, e.at);
                        chk("key_code", int'(kif.key_code), e.code);
                        cur_code = e.code;
                    end
                end else if (kif.key_valid) begin
                    chk("key_code_stable", int'(kif.key_code), cur_code);
                end
                if (kif.overrun) begin
                    if (q_ovr.size() == 0) begin
                        nvec++; nerr++;
                        $display("FAIL unexpected_overrun: at edge %0d, none expected", ecnt);
                    end else chk("overrun_edge", ecnt, q_ovr.pop_front());
                end
                if (kif.long_press) begin
                    if (q_lp.size() == 0) begin
                        nvec++; nerr++;
                        $display("FAIL unexpected_long_press: at edge %0d, none expected", ecnt);
                    end else chk("long_press_edge", ecnt, q_lp.pop_front());
                end
                if (q_key.size() > 0 && q_key[0].at < ecnt) begin
                    nvec++; nerr++;
                    $display("FAIL missed_key_valid: not observed, expected code %0d at edge %0d", q_key[0].code, q_key[0].at);
                    void'(q_key.pop_front());
                end
                if (q_ovr.size() > 0 && q_ovr[0] < ecnt) begin
                    nvec++; nerr++;
                    $display("FAIL missed_overrun: not observed, expected at edge %0d", q_ovr[0]);
                    void'(q_ovr.pop_front());
                end
                if (q_lp.size() > 0 && q_lp[0] < ecnt) begin
                    nvec++; nerr++;
                    $display("FAIL missed_long_press: not observed, expected at edge %0d", q_lp[0]);
                    void'(q_lp.pop_front());
                end
                kv_prev = kif.key_valid;
                if (kif.key_valid && !kif.key_ack && (auto_ack || ack_req != ack_done) && kv_prev) begin
                    kif.key_ack = 1'b1;
                    ack_done = ack_req;
                end
            end
        end
    end

    // Stimulus: directed scenarios, then random key patterns.
    initial begin : stim
        logic [ROWS*COLS-1:0] k;
        int sel, a, b;
        keys = '0;
        rst  = 1'b1;
        repeat (3) @(posedge f4m);
        @(negedge f4m);
        #1 rst = 1'b0;
        frames('0, 2);
        // single press of code 6 (row 1, column 2)
        frames(kb(6), 5);
        frames('0, 4);
        // bouncing key never accepted
        repeat (3) begin frames(kb(3), 1); frames('0, 1); end
        // accepted press, one-frame dropout, steady release
        frames(kb(3), 4); frames('0, 1); frames(kb(3), 2); frames('0, 4);
        // multi-key rejection, then the remaining key is accepted
        frames(kb(0) | kb(5), 4); frames(kb(0), 4); frames('0, 4);
        // overrun: unacked key 4, then key 9 accepted
        auto_ack = 1'b0;
        frames(kb(4), 4); frames('0, 4); frames(kb(9), 4);
        pending = 1'b0; ack_req++; auto_ack = 1'b1;
        // keep key 9 down into long press (and repeat when built in)
        frames(kb(9), 7); frames('0, 4);
        // reset mid-debounce with the key down: re-detected afterwards
        frames(kb(7), 2);
        do_reset();
        frames(kb(7), 4); frames('0, 4);
        // random patterns
        repeat (40) begin
            sel = int'($urandom_range(0, 3));
            a   = int'($urandom_range(0, ROWS*COLS-1));
            b   = (a + 1 + int'($urandom_range(0, ROWS*COLS-2))) % (ROWS*COLS);
            case (sel)
                0:       k = '0;
                3:       k = kb(a) | kb(b);
                default: k = kb(a);
            endcase
            frames(k, int'($urandom_range(1, 6)));
        end
        frames('0, 5);
        repeat (2) @(negedge f4m);
        chk("leftover_key_valid", q_key.size(), 0);
        chk("leftover_overrun", q_ovr.size(), 0);
        chk("leftover_long_press", q_lp.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
